// File: rtl/fft_iter.sv
// rtl/fft_iter.sv - iterative in-place radix-2 DIT FFT/IFFT with streaming load and dump
module fft_iter #(
    parameter int LOG2N = 3,
    parameter int DW    = 16,
    parameter int FRAC  = 11,
    parameter int SCALE = 0
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              inv,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*DW-1:0]   in_data,
    output logic [LOG2N-2:0]  tw_addr,
    input  logic [2*DW-1:0]   tw_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*DW-1:0]   out_data,
    output logic              out_last,
    output logic              busy,
    output logic              ovf
);
    localparam int N = 1 << LOG2N;
    localparam logic [LOG2N-1:0] CNT_MAX = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] K_MAX   = LOG2N'(N / 2 - 1);

    typedef enum logic [1:0] {LOAD, FULL, CALC, DUMP} state_t;
    state_t state, state_nx;

    logic [2*DW-1:0]  mem [N];
    logic [LOG2N-1:0] cnt;       // sample index in LOAD/DUMP, butterfly index in CALC
    logic [3:0]       stg;
    logic             inv_q;

    logic [LOG2N-1:0] rev, half, pos, grp, a_idx, b_idx;
    logic             k_last, stg_last;

    // Sign-magnitude product truncated toward zero, matching the legacy butterfly.
    function automatic logic signed [DW-1:0] pmul(input logic signed [DW-1:0] x,
                                                  input logic signed [DW-1:0] y);
        logic [DW-1:0]   mx, my, mag;
        logic [2*DW-1:0] prod;
        mx   = x[DW-1] ? DW'(-x) : DW'(x);
        my   = y[DW-1] ? DW'(-y) : DW'(y);
        prod = {{DW{1'b0}}, mx} * {{DW{1'b0}}, my};
        mag  = DW'(prod >> FRAC);
        return (x[DW-1] ^ y[DW-1]) ? $signed(-mag) : $signed(mag);
    endfunction

    function automatic logic [DW:0] sadd(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                         input logic sub);
        return sub ? ({x[DW-1], x} - {y[DW-1], y}) : ({x[DW-1], x} + {y[DW-1], y});
    endfunction

    always_comb begin
        rev = '0;
        for (int i = 0; i < LOG2N; i++) rev[i] = cnt[LOG2N-1-i];
        half     = LOG2N'(1) << stg;
        pos      = cnt & (half - LOG2N'(1));
        grp      = cnt >> stg;
        a_idx    = (grp << (stg + 4'd1)) | pos;
        b_idx    = a_idx | half;
        k_last   = (cnt == K_MAX);
        stg_last = (stg == 4'(LOG2N - 1));
    end

    logic signed [DW-1:0] ar, ai, br, bi, wr, wi, tre, tim;
    logic [DW:0]          tre_s, tim_s, yar_s, yai_s, ybr_s, ybi_s;
    logic [DW-1:0]        yar, yai, ybr, ybi;
    logic                 bf_ovf;

    always_comb begin
        {ar, ai} = mem[a_idx];
        {br, bi} = mem[b_idx];
        wr       = tw_data[2*DW-1:DW];
        wi       = inv_q ? -$signed(tw_data[DW-1:0]) : $signed(tw_data[DW-1:0]);
        tre_s    = sadd(pmul(br, wr), pmul(bi, wi), 1'b1);
        tim_s    = sadd(pmul(br, wi), pmul(bi, wr), 1'b0);
        tre      = tre_s[DW-1:0];
        tim      = tim_s[DW-1:0];
        yar_s    = sadd(ar, tre, 1'b0);
        yai_s    = sadd(ai, tim, 1'b0);
        ybr_s    = sadd(ar, tre, 1'b1);
        ybi_s    = sadd(ai, tim, 1'b1);
        // Scaled mode keeps the carry bit, so the outputs themselves cannot overflow.
        yar      = (SCALE != 0) ? yar_s[DW:1] : yar_s[DW-1:0];
        yai      = (SCALE != 0) ? yai_s[DW:1] : yai_s[DW-1:0];
        ybr      = (SCALE != 0) ? ybr_s[DW:1] : ybr_s[DW-1:0];
        ybi      = (SCALE != 0) ? ybi_s[DW:1] : ybi_s[DW-1:0];
        bf_ovf   = (tre_s[DW] ^ tre_s[DW-1]) | (tim_s[DW] ^ tim_s[DW-1]);
        if (SCALE == 0)
            bf_ovf = bf_ovf | (yar_s[DW] ^ yar_s[DW-1]) | (yai_s[DW] ^ yai_s[DW-1])
                            | (ybr_s[DW] ^ ybr_s[DW-1]) | (ybi_s[DW] ^ ybi_s[DW-1]);
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        out_data  = mem[cnt];
        tw_addr   = '0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && cnt == CNT_MAX) state_nx = FULL;
            end
            FULL: state_nx = CALC;
            CALC: begin
                busy    = 1'b1;
                tw_addr = (LOG2N-1)'(pos << (4'(LOG2N - 1) - stg));
                if (k_last && stg_last) state_nx = DUMP;
            end
            DUMP: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = (cnt == CNT_MAX);
                if (out_ready && cnt == CNT_MAX) state_nx = LOAD;
            end
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge ck) begin
        if (!rst) begin
            state <= LOAD;
            cnt   <= '0;
            stg   <= '0;
            inv_q <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                LOAD: if (in_valid) begin
                    cnt <= cnt + LOG2N'(1);
                    if (cnt == '0) begin
                        inv_q <= inv;
                        ovf   <= 1'b0;
                    end
                end
                CALC: begin
                    ovf <= ovf | bf_ovf;
                    if (k_last) begin
                        cnt <= '0;
                        stg <= stg_last ? 4'd0 : stg + 4'd1;
                    end else begin
                        cnt <= cnt + LOG2N'(1);
                    end
                end
                DUMP: if (out_ready) cnt <= cnt + LOG2N'(1);
                default: ;
            endcase
        end
    end

    // Data array is deliberately left out of reset.
    always_ff @(posedge ck) begin
        if (rst) begin
            if (state == LOAD && in_valid) begin
                mem[rev] <= in_data;
            end else if (state == CALC) begin
                mem[a_idx] <= {yar, yai};
                mem[b_idx] <= {ybr, ybi};
            end
        end
    end
endmodule
